// File: rtl/serial_adder_nbit.sv
// Bit-serial adder/subtractor: one full-adder stage and a carry flip-flop,
// processing operands LSB first, one bit per clock.
module serial_adder_nbit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, b_sh, acc;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             bit_s, carry_next, last_bit;

   always_comb begin
      bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
      carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
      last_bit   = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The result registers are written only on the final bit, so partial sums never show.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == IDLE && start) begin
         a_sh  <= a;
         b_sh  <= sub ? ~b : b;
         carry <= sub ? 1'b1 : cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         carry <= carry_next;
         cnt   <= cnt + CW'(1);
         acc   <= {bit_s, acc[WIDTH-1:1]};
         if (last_bit) begin
            sum  <= {bit_s, acc[WIDTH-1:1]};
            cout <= carry_next;
            ovf  <= carry ^ carry_next;
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed and exhaustive checks of serial_adder_nbit at WIDTH=8 and WIDTH=4.
module tb_serial_adder_nbit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;
   logic       start4, sub4, cin4, busy4, done4, cout4, ovf4;
   logic [3:0] a4, b4, sum4;

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder_nbit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   serial_adder_nbit #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 operation with latency, busy, and no-partial-result checks.
   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic s,
                      input logic [7:0] es, input logic ec, input logic eo);
      int         lat;
      logic [7:0] prev;
      prev = sum8;
      @(negedge clk);
      a8 = a; b8 = b; cin8 = ci; sub8 = s; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = ~a; b8 = a; cin8 = ~ci; sub8 = ~s;
      lat = 0;
      while (done8 !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (lat >= 1 && lat <= 7) begin
            chk({tag, "_busy"}, busy8, 1'b1);
            chk({tag, "_hold"}, sum8, prev);
         end
      end
      chk({tag, "_lat"}, lat, 8);
      chk({tag, "_sum"}, sum8, es);
      chk({tag, "_cout"}, cout8, ec);
      chk({tag, "_ovf"}, ovf8, eo);
      chk({tag, "_busy_done"}, busy8, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, done8, 1'b0);
   endtask

   // One WIDTH=4 operation checked against signed/unsigned integer arithmetic.
   task automatic op4(input int a, input int b, input int ci, input int s);
      int lat, full, sa, sb, sres, es, ec, eo;
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      if (s == 0) begin
         full = a + b + ci;
         es   = full % 16;
         ec   = (full > 15) ? 1 : 0;
         sres = sa + sb + ci;
      end else begin
         es   = (a - b + 16) % 16;
         ec   = (a >= b) ? 1 : 0;
         sres = sa - sb;
      end
      eo = (sres > 7 || sres < -8) ? 1 : 0;
      @(negedge clk);
      a4 = 4'(a); b4 = 4'(b); cin4 = ci[0]; sub4 = s[0]; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      lat = 0;
      while (done4 !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("w4_lat_%0d_%0d_%0d_%0d", a, b, ci, s), lat, 4);
      chk($sformatf("w4_sum_%0d_%0d_%0d_%0d", a, b, ci, s), sum4, es);
      chk($sformatf("w4_cout_%0d_%0d_%0d_%0d", a, b, ci, s), cout4, ec);
      chk($sformatf("w4_ovf_%0d_%0d_%0d_%0d", a, b, ci, s), ovf4, eo);
      @(posedge clk); #1;
   endtask

   initial begin
      int dones;
      rst = 1'b1;
      start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
      #2;
      chk("rst_busy", busy8, 1'b0);
      chk("rst_done", done8, 1'b0);
      chk("rst_sum", sum8, 8'h00);
      chk("rst_cout", cout8, 1'b0);
      chk("rst_ovf", ovf8, 1'b0);
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;

      op8("add_00_00", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      op8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      op8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

      // Start requests during RUN and DONE must be ignored.
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      dones = 0;
      for (int e = 1; e <= 11; e++) begin
         @(negedge clk);
         start8 = (e == 3 || e == 9);
         a8 = 8'hFF; b8 = 8'hFF; sub8 = (e == 3); cin8 = 1'b1;
         @(posedge clk); #1;
         if (done8 === 1'b1) dones++;
         if (e == 4) chk("ign_busy_run", busy8, 1'b1);
         if (e == 8) begin
            chk("ign_done", done8, 1'b1);
            chk("ign_sum", sum8, 8'h30);
         end
         if (e == 9)  chk("ign_busy_after_done", busy8, 1'b0);
         if (e == 10) chk("ign_busy_idle", busy8, 1'b0);
      end
      start8 = 1'b0;
      chk("ign_done_count", dones, 1);
      chk("ign_sum_hold", sum8, 8'h30);

      // Reset in the middle of an operation aborts it with no done pulse.
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy8, 1'b0);
      chk("abort_done", done8, 1'b0);
      chk("abort_sum", sum8, 8'h00);
      chk("abort_cout", cout8, 1'b0);
      chk("abort_ovf", ovf8, 1'b0);
      dones = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (done8 === 1'b1) dones++;
      end
      chk("abort_no_done", dones, 0);
      #1;
      rst = 1'b0;
      op8("post_rst_03_04", 8'h03, 8'h04, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0);

      // Exhaustive WIDTH=4 sweep with back-to-back starts.
      for (int s = 0; s < 2; s++)
         for (int ci = 0; ci < 2; ci++)
            for (int a = 0; a < 16; a++)
               for (int b = 0; b < 16; b++)
                  op4(a, b, ci, s);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
